// File: rtl/md_scheduler.sv
// Shares one multi-cycle mult/div unit between two requesters: round-robin grant, operand
// latching, start/done sequencing, held response with backpressure, flush and watchdog abort.
module md_scheduler #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  r_valid,
  input  logic [3:0]  r_op,
  input  logic [63:0] r_a,
  input  logic [63:0] r_b,
  output logic [1:0]  r_ready,
  input  logic [1:0]  flush,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_err,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_done,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        md_kill
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              drop_q, drop_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              err_q, err_d;

  logic              grant;
  logic              accept;
  logic              own_flush;

  // On a tie the port that did not finish last wins; otherwise the lone valid port.
  assign grant     = (r_valid == 2'b11) ? ~last_q : r_valid[1];
  assign accept    = (state_q == IDLE) && r_valid[grant] && !flush[grant];
  assign own_flush = flush[owner_q];

  assign r_ready   = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign rsp_err   = err_q;
  assign md_start  = (state_q == ISSUE);
  assign md_op     = op_q;
  assign md_a      = a_q;
  assign md_b      = b_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    drop_d  = drop_q;
    wdog_d  = wdog_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    md_kill = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          op_d    = grant ? r_op[3:2]  : r_op[1:0];
          a_d     = grant ? r_a[63:32] : r_a[31:0];
          b_d     = grant ? r_b[63:32] : r_b[31:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The unit cannot be cancelled before start, so a flush here only marks the result.
        wdog_d  = '0;
        drop_d  = own_flush;
        state_d = WAIT;
      end
      WAIT: begin
        if (md_done || (wdog_q == WDOG_LAST)) begin
          if (md_done) begin
            hi_d  = md_hi;
            lo_d  = md_lo;
            err_d = 1'b0;
          end else begin
            md_kill = 1'b1;
            hi_d    = '0;
            lo_d    = '0;
            err_d   = 1'b1;
          end
          if (drop_q || own_flush) begin
            state_d = IDLE;
            last_d  = owner_q;
          end else begin
            state_d = RESP;
          end
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
          if (own_flush) drop_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q] || own_flush) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      drop_q  <= 1'b0;
      wdog_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
      wdog_q  <= wdog_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Shares one multi-cycle multiply/divide unit (mult/multu/div/divu, HI/LO result) between two requesters, e.g. the core E-stage (port 0) and a coprocessor/debug port (port 1).
- Arbitrates round-robin, latches operands, and sequences the unit through a start/done handshake.
- Returns HI/LO to the owning requester with valid/ready backpressure.
- Provides per-requester flush and a watchdog timeout that kills a hung unit.

Parameters:
- TIMEOUT, 16: max cycles in WAIT before abort; must be at least 2 and greater than the unit's worst-case latency.
- CNT_W, 5: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- r_valid  in  2  request valid, bit i = requester i.
- r_op  in  4  op per requester, [2i+1:2i]: 00 mult, 01 multu, 10 div, 11 divu.
- r_a  in  64  operand A, [32i+31:32i].
- r_b  in  64  operand B, [32i+31:32i].
- r_ready  out  2  request accepted this cycle.
- flush  in  2  cancel requester i's accepted, not-yet-consumed op.
- rsp_valid  out  2  response valid for requester i; one-hot or zero.
- rsp_ready  in  2  requester i consumes response.
- rsp_hi  out  32  HI result (remainder for div).
- rsp_lo  out  32  LO result (quotient for div).
- rsp_err  out  1  response is a timeout abort; hi/lo are 0.
- md_start  out  1  one-cycle start pulse to the unit.
- md_op  out  2  latched op, same encoding as r_op.
- md_a  out  32  latched operand A.
- md_b  out  32  latched operand B.
- md_done  in  1  unit result valid, one-cycle pulse.
- md_hi  in  32  unit HI, valid with md_done.
- md_lo  in  32  unit LO, valid with md_done.
- md_kill  out  1  one-cycle pulse forcing the unit back to idle.

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE, owner=0, last=1 (port 0 wins the first tie), drop=0, wdog=0.
  - Latched op/a/b = 0, hi/lo/err = 0.
  - All outputs 0.
  - Reset mid-operation discards all work and does not pulse md_kill.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant:
  - grant = the single valid requester; if both are valid, grant = ~last.
  - r_ready[grant] = 1, combinational, only in IDLE and only when r_valid[grant]=1 and flush[grant]=0.
  - On accept, latch op/a/b from the granted slice, set owner=grant, go to ISSUE.
  - A request with flush asserted in the same cycle is not accepted.
- ISSUE:
  - md_start=1 for exactly this cycle; md_op/md_a/md_b hold latched values until the next accept.
  - wdog=0, drop=0; go to WAIT.
  - flush[owner] in ISSUE sets drop=1. md_start still fires, because the unit cannot be cancelled before start.
- WAIT:
  - md_done=1: capture md_hi/md_lo, err=0. If drop is set or flush[owner]=1, go to IDLE (result discarded, last=owner). Otherwise go to RESP.
  - No md_done and wdog==TIMEOUT-1: md_kill=1 this cycle, hi=lo=0, err=1. Go to RESP, or to IDLE if drop is set or flush[owner]=1.
  - Otherwise wdog increments; flush[owner] sets drop=1.
  - Latency from accept to earliest rsp_valid is 3 cycles for a unit with 1-cycle done latency.
- RESP:
  - rsp_valid[owner]=1; rsp_hi/rsp_lo/rsp_err are stable and held until consumed.
  - rsp_ready[owner]=1: consumed, last=owner, go to IDLE.
  - flush[owner]=1 without rsp_ready: discard, last=owner, go to IDLE.
  - If both are asserted, the flush wins (nothing consumed); the result is identical either way.
  - rsp_ready of the non-owner is ignored.
- md_done outside WAIT is ignored; no state change.
- Only one operation is ever outstanding. No new accept until the FSM returns to IDLE, so back-to-back ops cost one IDLE cycle each.
- The block performs no arithmetic and passes div-by-zero results through unchanged.
- Non-owner flush is ignored except in IDLE, where it suppresses acceptance.

Test Plan:
- Single op: port0 mult, a=0xFFFFFFFE, b=3, unit model done 5 cycles after start returning hi=0xFFFFFFFF, lo=0xFFFFFFFA -> r_ready[0] at t0, md_start at t0+1, rsp_valid=01 at t0+7, hi/lo match, err=0.
- Round-robin: both ports valid continuously with divu (100/7, 9/2) -> grants alternate 0,1,0,1. Port0 gets hi=2/lo=14, port1 gets hi=1/lo=4. No port is granted twice in a row.
- Backpressure: hold rsp_ready[1]=0 for 4 cycles after rsp_valid[1] rises -> rsp_valid and data stable for all 4 cycles; r_ready stays 00; IDLE is reached 1 cycle after rsp_ready[1]=1.
- Flush in WAIT: flush[0] pulsed 2 cycles after md_start, done arrives later -> no rsp_valid[0]; the next request is accepted in the cycle after md_done.
- Timeout: unit never raises md_done, TIMEOUT=16 -> md_kill pulses exactly once, 16 cycles after md_start; rsp_valid[owner]=1, err=1, hi=lo=0.
- Reset mid-WAIT: reset=0 for one cycle -> all outputs 0 next cycle; a later md_done is ignored; a fresh request is served normally, with port 0 winning the first tie.
